// File: rtl/dawson_sequencer.sv
// dawson_sequencer: queues {a, b, tag} requests and feeds them one at a time
// through a strobe/ack Dawson arithmetic unit, returning result and tag.
// Optional build macro DAWSON_SEQ_OVF_EN enables the sticky overflow flag for
// requests dropped while the queue is full. Without it, overflow is tied low.
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | waiting for a queued request; pops the head when one exists
// SEND_A | presenting operand A, waiting for input_a_ack
// SEND_B | presenting operand B, waiting for input_b_ack
// WAIT_Z | acknowledging the unit's result strobe, capturing output_z
// DONE   | one-cycle ready_out pulse, then back to IDLE
module dawson_sequencer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [TAG_W-1:0]           tag,
    input  logic                       ready_in,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           out,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       ready_out,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [WIDTH-1:0]           input_a,
    output logic [WIDTH-1:0]           input_b,
    output logic                       input_a_stb,
    output logic                       input_b_stb,
    output logic                       output_z_ack,
    input  logic                       input_a_ack,
    input  logic                       input_b_ack,
    input  logic                       output_z_stb,
    input  logic [WIDTH-1:0]           output_z
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [TAG_W-1:0] mem_t [DEPTH];

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] op_a, op_b;
    logic [TAG_W-1:0] op_tag;
    logic [WIDTH-1:0] out_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             push, pop, capture;

    // full is taken from the registered count, so a pop in the same cycle
    // never makes room for a push (no bypass).
    assign full    = (count_r == CW'(DEPTH));
    assign push    = ready_in & ~full;
    assign pop     = (state == IDLE) & (count_r != '0);
    assign capture = (state == WAIT_Z) & output_z_stb;
    assign count   = count_r;
    assign out     = out_r;
    assign out_tag = out_tag_r;

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr] <= a;
            mem_b[wr_ptr] <= b;
            mem_t[wr_ptr] <= tag;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // State register plus the operand/tag latch for the request in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            op_tag <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                op_a   <= mem_a[rd_ptr];
                op_b   <= mem_b[rd_ptr];
                op_tag <= mem_t[rd_ptr];
            end
        end
    end

    // Result registers hold their value until the next capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_r     <= '0;
            out_tag_r <= '0;
        end else if (capture) begin
            out_r     <= output_z;
            out_tag_r <= op_tag;
        end
    end

    // Next-state and handshake outputs; acks outside their state are ignored.
    always_comb begin
        state_nxt    = state;
        input_a      = '0;
        input_b      = '0;
        input_a_stb  = 1'b0;
        input_b_stb  = 1'b0;
        output_z_ack = 1'b0;
        ready_out    = 1'b0;
        case (state)
            IDLE: begin
                if (count_r != '0) state_nxt = SEND_A;
            end
            SEND_A: begin
                input_a     = op_a;
                input_a_stb = 1'b1;
                if (input_a_ack) state_nxt = SEND_B;
            end
            SEND_B: begin
                input_b     = op_b;
                input_b_stb = 1'b1;
                if (input_b_ack) state_nxt = WAIT_Z;
            end
            WAIT_Z: begin
                output_z_ack = output_z_stb;
                if (output_z_stb) state_nxt = DONE;
            end
            DONE: begin
                ready_out = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DAWSON_SEQ_OVF_EN
    logic drop;
    assign drop = ready_in & full;

    // Sticky drop flag; a new drop wins over a same-edge clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_dawson_sequencer.sv
// tb_dawson_sequencer: scoreboard bench for dawson_sequencer with a stub
// arithmetic unit (double add or XOR, optional ack delay and hold).
module tb_dawson_sequencer;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clock, reset_n;
    logic [WIDTH-1:0] a, b;
    logic [TAG_W-1:0] tag;
    logic             ready_in, full, ready_out, overflow, ovf_clr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] out, input_a, input_b, output_z;
    logic [TAG_W-1:0] out_tag;
    logic             input_a_stb, input_b_stb, output_z_ack;
    logic             input_a_ack, input_b_ack, output_z_stb;

    dawson_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset_n(reset_n), .a(a), .b(b), .tag(tag),
        .ready_in(ready_in), .full(full), .count(count), .out(out),
        .out_tag(out_tag), .ready_out(ready_out), .overflow(overflow),
        .ovf_clr(ovf_clr), .input_a(input_a), .input_b(input_b),
        .input_a_stb(input_a_stb), .input_b_stb(input_b_stb),
        .output_z_ack(output_z_ack), .input_a_ack(input_a_ack),
        .input_b_ack(input_b_ack), .output_z_stb(output_z_stb),
        .output_z(output_z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests  = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- stub arithmetic unit ----------------
    logic        mode_add, hold_ab, hold_z;
    int          delay;
    int          a_cnt, b_cnt, z_cnt;
    logic [63:0] ca, zres;
    logic        z_pend;

    assign input_a_ack  = input_a_stb && !hold_ab && (a_cnt >= delay);
    assign input_b_ack  = input_b_stb && !hold_ab && (b_cnt >= delay);
    assign output_z_stb = z_pend && !hold_z && (z_cnt >= delay);
    assign output_z     = zres;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
            ca <= '0; zres <= '0; z_pend <= 1'b0;
        end else begin
            a_cnt <= (input_a_stb && !input_a_ack) ? a_cnt + 1 : 0;
            b_cnt <= (input_b_stb && !input_b_ack) ? b_cnt + 1 : 0;
            z_cnt <= (z_pend && !output_z_stb) ? z_cnt + 1 : 0;
            if (input_a_stb && input_a_ack) ca <= input_a;
            if (input_b_stb && input_b_ack) begin
                zres   <= mode_add ? $realtobits($bitstoreal(ca) + $bitstoreal(input_b))
                                   : (ca ^ input_b);
                z_pend <= 1'b1;
            end
            if (output_z_stb && output_z_ack) z_pend <= 1'b0;
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [63:0]      val;
        logic [TAG_W-1:0] t;
    } exp_t;
    exp_t sb[$];

    int          pulses = 0;
    int          peak   = 0;
    int          viol   = 0;
    logic        pa_stb, pa_ack, pb_stb, pb_ack;
    logic [63:0] pa_val, pb_val;

    always @(negedge clock) begin
        if (!reset_n) begin
            pa_stb = 1'b0; pa_ack = 1'b0; pb_stb = 1'b0; pb_ack = 1'b0;
        end else begin
            if (int'(count) > peak) peak = int'(count);
            if (pa_stb && !pa_ack && !(input_a_stb && input_a == pa_val)) viol++;
            if (pb_stb && !pb_ack && !(input_b_stb && input_b == pb_val)) viol++;
            pa_stb = input_a_stb; pa_ack = input_a_ack; pa_val = input_a;
            pb_stb = input_b_stb; pb_ack = input_b_ack; pb_val = input_b;
            if (ready_out) begin
                pulses++;
                if (sb.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_pulse: got out=%h tag=%0d expected no pulse", out, out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_out", out, e.val);
                    chk("result_tag", 64'(out_tag), 64'(e.t));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; presents one request for one clock edge.
    task automatic drive(input logic [63:0] va, input logic [63:0] vb,
                         input logic [TAG_W-1:0] vt, input logic expect_it,
                         input logic [63:0] vexp);
        exp_t e;
        a = va; b = vb; tag = vt; ready_in = 1'b1;
        if (expect_it) begin
            e.val = vexp; e.t = vt;
            sb.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        chk(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    logic [63:0] xa [4];
    logic [63:0] xb [4];
    logic [63:0] xe [4];
    logic [63:0] fa [5];
    logic [63:0] fb [5];
    logic [63:0] fe [5];

    initial begin
        int lat, pulses_before;
        xa[0] = 64'hFFFF0000FFFF0000; xb[0] = 64'h0F0F0F0F0F0F0F0F; xe[0] = 64'hF0F00F0FF0F00F0F;
        xa[1] = 64'h1;                xb[1] = 64'h3;                xe[1] = 64'h2;
        xa[2] = 64'hAAAAAAAAAAAAAAAA; xb[2] = 64'h5555555555555555; xe[2] = 64'hFFFFFFFFFFFFFFFF;
        xa[3] = 64'h0123456789ABCDEF; xb[3] = 64'h0;                xe[3] = 64'h0123456789ABCDEF;
        fa[0] = 64'h1;   fb[0] = 64'h2;  fe[0] = 64'h3;
        fa[1] = 64'h4;   fb[1] = 64'h1;  fe[1] = 64'h5;
        fa[2] = 64'h8;   fb[2] = 64'h8;  fe[2] = 64'h0;
        fa[3] = 64'hF0;  fb[3] = 64'h0F; fe[3] = 64'hFF;
        fa[4] = 64'h100; fb[4] = 64'h1;  fe[4] = 64'h101;

        reset_n = 1'b0; ready_in = 1'b0; ovf_clr = 1'b0;
        a = '0; b = '0; tag = '0;
        mode_add = 1'b1; hold_ab = 1'b0; hold_z = 1'b0; delay = 0;
        repeat (3) @(negedge clock);
        chk("rst_out", out, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_ready_out", 64'(ready_out), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_strobes", 64'({input_a_stb, input_b_stb, output_z_ack}), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1.0 + 2.0 = 3.0; latency counts edges from the enqueue edge
        // (inclusive) to the edge that opens the ready_out cycle.
        a = 64'h3FF0000000000000; b = 64'h4000000000000000; tag = 2'd1;
        sb.push_back('{val: 64'h4008000000000000, t: 2'd1});
        ready_in = 1'b1;
        @(posedge clock);
        #1 ready_in = 1'b0;
        lat = 1;
        while (!ready_out && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        chk("latency", 64'(lat), 64'd5);
        drain("add_drain", 20);

        // Four back-to-back XOR requests, tags 0..3.
        mode_add = 1'b0;
        for (int i = 0; i < 4; i++) drive(xa[i], xb[i], TAG_W'(i), 1'b1, xe[i]);
        ready_in = 1'b0;
        drain("xor_drain", 100);
        tests++;
        if (peak != 3 && peak != 4) begin
            errors++;
            $display("FAIL count_peak: got %0d expected 3 or 4", peak);
        end

        // Three-cycle delay on every handshake.
        delay = 3;
        drive(64'h1111, 64'h2222, 2'd2, 1'b1, 64'h3333);
        drive(64'hFF,   64'h0F,   2'd3, 1'b1, 64'hF0);
        ready_in = 1'b0;
        drain("delay_drain", 100);
        chk("strobe_stable", 64'(viol), 64'd0);
        delay = 0;

        // Acks held low: first request sticks in SEND_A, next four fill the queue.
        hold_ab = 1'b1;
        for (int i = 0; i < 5; i++) drive(fa[i], fb[i], TAG_W'(i), 1'b1, fe[i]);
        ready_in = 1'b0;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_full", 64'(full), 64'd1);
        chk("held_in_send_a", 64'(input_a_stb), 64'd1);
        drive(64'hDEAD, 64'h0, 2'd1, 1'b0, 64'h0);
        ready_in = 1'b0;
        chk("drop_count", 64'(count), 64'd4);
`ifdef DAWSON_SEQ_OVF_EN
        chk("drop_overflow", 64'(overflow), 64'd1);
`else
        chk("drop_overflow", 64'(overflow), 64'd0);
`endif
        ovf_clr = 1'b1;
        @(negedge clock);
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'd0);
        hold_ab = 1'b0;
        drain("fill_drain", 100);

        // Reset while the head is in WAIT_Z and two more are queued.
        hold_z = 1'b1;
        for (int i = 0; i < 3; i++) drive(xa[i], xb[i], TAG_W'(i), 1'b0, 64'h0);
        ready_in = 1'b0;
        repeat (4) @(negedge clock);
        chk("pre_reset_count", 64'(count), 64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_full", 64'(full), 64'd0);
        chk("midrst_out", out, 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
        chk("midrst_ready_out", 64'(ready_out), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        chk("midrst_strobes", 64'({input_a_stb, input_b_stb, output_z_ack}), 64'd0);
        sb.delete();
        pulses_before = pulses;
        @(negedge clock);
        reset_n = 1'b1;
        hold_z  = 1'b0;
        repeat (20) @(negedge clock);
        chk("post_reset_pulses", 64'(pulses - pulses_before), 64'd0);
        chk("post_reset_count", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
